// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: fetch FSM states, i_jump encodings and PC constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  JUMP_NONE        = 2'b00;
  localparam logic [1:0]  JUMP_J           = 2'b01;
  localparam logic [1:0]  JUMP_JR          = 2'b10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: branch kill beats keep, keep beats flush, flush beats a new load.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_branch_final,
  input  logic        i_keep,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_instruction <= '0;
      o_pc_plus4    <= '0;
      o_valid       <= 1'b0;
    end else if (i_branch_final || (!i_keep && (i_flush || !i_load))) begin
      // data fields are left as they were; only the valid bit is killed
      o_valid <= 1'b0;
    end else if (!i_keep) begin
      o_instruction <= i_instruction;
      o_pc_plus4    <= i_pc_plus4;
      o_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM and IF/ID register.
// Optional saturating stall/flush counters are built only with FETCH_PERF_CNT_EN defined.
//
// state  | meaning
// S_REQ  | o_imem_req asserted for o_pc
// S_WAIT | request granted, waiting for rvalid
// S_DROP | waiting for rvalid of a stale request, data discarded
// S_HOLD | response held in the one-entry buffer while stalled
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pc_keep,
  input  logic        i_IF_ID_keep,
  input  logic        i_IF_ID_flush,
  input  logic        i_branch_final,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  input  logic [1:0]  i_jump,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_IF_ID_instruction,
  output logic [31:0] o_IF_ID_pc_plus4,
  output logic        o_IF_ID_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_stall_count,
  output logic [31:0] o_flush_count
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, hold_buf, word;
  logic         jump_j, jump_jr, redirect, hold_req, word_avail, accept, buf_wr;

  assign jump_j     = (i_jump == JUMP_J);
  assign jump_jr    = (i_jump == JUMP_JR);
  assign redirect   = i_branch_final | (~i_pc_keep & (jump_j | jump_jr));
  assign hold_req   = i_pc_keep | i_IF_ID_keep;
  assign word_avail = ((state == S_WAIT) & i_imem_rvalid) | (state == S_HOLD);
  assign accept     = word_avail & ~redirect & ~hold_req & ~i_IF_ID_flush;
  assign buf_wr     = (state == S_WAIT) & i_imem_rvalid & ~redirect & hold_req;
  assign word       = (state == S_HOLD) ? hold_buf : i_imem_rdata;

  // request is gated by reset so no grant can be taken while the pipe is being reset
  assign o_imem_req  = (state == S_REQ) & reset;
  assign o_imem_addr = pc;
  assign o_pc        = pc;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:  if (i_imem_gnt) state_nxt = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid)  state_nxt = (!redirect && hold_req) ? S_HOLD : S_REQ;
        else if (redirect)  state_nxt = S_DROP;
      end
      S_DROP: if (i_imem_rvalid) state_nxt = S_REQ;
      S_HOLD: if (redirect || !hold_req) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (i_branch_final)  pc_nxt = i_branch_target;
    else if (i_pc_keep)  pc_nxt = pc;
    else if (jump_j)     pc_nxt = i_jump_target;
    else if (jump_jr)    pc_nxt = i_jr_target;
    else if (accept)     pc_nxt = pc + INSTR_BYTES;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      hold_buf <= '0;
      // a response still in flight must be swallowed after reset is released
      state    <= ((state == S_WAIT || state == S_DROP) && !i_imem_rvalid) ? S_DROP : S_REQ;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      if (buf_wr) hold_buf <= i_imem_rdata;
    end
  end

  if_id_reg u_if_id_reg (
    .clk            (clk),
    .reset          (reset),
    .i_branch_final (i_branch_final),
    .i_keep         (i_IF_ID_keep),
    .i_flush        (i_IF_ID_flush),
    .i_load         (accept),
    .i_instruction  (word),
    .i_pc_plus4     (pc + INSTR_BYTES),
    .o_instruction  (o_IF_ID_instruction),
    .o_pc_plus4     (o_IF_ID_pc_plus4),
    .o_valid        (o_IF_ID_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (i_pc_keep && stall_count != '1) stall_count <= stall_count + 32'd1;
      if ((i_IF_ID_flush || i_branch_final) && flush_count != '1) flush_count <= flush_count + 32'd1;
    end
  end

  assign o_stall_count = stall_count;
  assign o_flush_count = flush_count;
`else
  assign o_stall_count = '0;
  assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;
  import pipeline_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk;
  logic        reset, i_pc_keep, i_IF_ID_keep, i_IF_ID_flush, i_branch_final;
  logic [31:0] i_branch_target, i_jump_target, i_jr_target;
  logic [1:0]  i_jump;
  logic        o_imem_req, i_imem_gnt, i_imem_rvalid;
  logic [31:0] o_imem_addr, i_imem_rdata;
  logic [31:0] o_IF_ID_instruction, o_IF_ID_pc_plus4, o_pc, o_stall_count, o_flush_count;
  logic        o_IF_ID_valid;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .i_pc_keep(i_pc_keep), .i_IF_ID_keep(i_IF_ID_keep), .i_IF_ID_flush(i_IF_ID_flush),
    .i_branch_final(i_branch_final), .i_branch_target(i_branch_target),
    .i_jump_target(i_jump_target), .i_jr_target(i_jr_target), .i_jump(i_jump),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_IF_ID_instruction(o_IF_ID_instruction), .o_IF_ID_pc_plus4(o_IF_ID_pc_plus4),
    .o_IF_ID_valid(o_IF_ID_valid), .o_pc(o_pc),
    .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus knobs
  logic        s_reset, s_pk, s_ik, s_fl, s_bf;
  logic [1:0]  s_jump;
  logic [31:0] s_bt, s_jt, s_jrt;
  bit          gnt_always, checking;
  int          dly_min, dly_max;

  // reference model: architectural view plus the single in-flight imem transaction
  logic [31:0] m_pc, m_instr, m_pc4, m_bufdata, m_rdata, m_stall, m_flush;
  logic        m_valid, m_buf, m_out, m_stale, exp_req;
  int          m_wait;

  int n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_update();
    logic redir, holdc, avail, acc;
    logic [31:0] w;
    redir = 1'b0;
    if (!reset) begin
      m_pc = RST_PC; m_valid = 1'b0; m_instr = '0; m_pc4 = '0;
      m_buf = 1'b0; m_stall = '0; m_flush = '0;
      if (m_out) m_stale = 1'b1;
    end else begin
      redir = i_branch_final || (!i_pc_keep && (i_jump == 2'b01 || i_jump == 2'b10));
      holdc = i_pc_keep || i_IF_ID_keep;
      avail = (m_out && !m_stale && i_imem_rvalid) || m_buf;
      w     = m_buf ? m_bufdata : i_imem_rdata;
      acc   = avail && !redir && !holdc && !i_IF_ID_flush;
      if (i_branch_final)     m_valid = 1'b0;
      else if (i_IF_ID_keep)  begin end
      else if (i_IF_ID_flush) m_valid = 1'b0;
      else if (acc)           begin m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; end
      else                    m_valid = 1'b0;
      if (avail && !redir && holdc) begin m_buf = 1'b1; m_bufdata = w; end
      else m_buf = 1'b0;
      if (i_branch_final)       m_pc = i_branch_target;
      else if (i_pc_keep)       begin end
      else if (i_jump == 2'b01) m_pc = i_jump_target;
      else if (i_jump == 2'b10) m_pc = i_jr_target;
      else if (acc)             m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
      if (i_pc_keep && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if ((i_IF_ID_flush || i_branch_final) && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
`endif
      if (m_out && redir) m_stale = 1'b1;
    end
    if (i_imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
    else if (m_out) m_wait = m_wait - 1;
    if (exp_req && i_imem_gnt) begin
      m_out   = 1'b1;
      m_stale = redir;
      m_wait  = int'($urandom_range(dly_max, dly_min));
      m_rdata = $urandom();
    end
  endtask

  task automatic step();
    @(negedge clk);
    reset = s_reset; i_pc_keep = s_pk; i_IF_ID_keep = s_ik; i_IF_ID_flush = s_fl;
    i_branch_final = s_bf; i_jump = s_jump;
    i_branch_target = s_bt; i_jump_target = s_jt; i_jr_target = s_jrt;
    exp_req       = s_reset && !m_out && !m_buf;
    i_imem_gnt    = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    i_imem_rvalid = m_out && (m_wait == 0);
    i_imem_rdata  = i_imem_rvalid ? m_rdata : $urandom();
    #1;
    if (checking) begin
      check("imem_req",    32'(o_imem_req), 32'(exp_req));
      check("imem_addr",   o_imem_addr, m_pc);
      check("pc",          o_pc, m_pc);
      check("ifid_valid",  32'(o_IF_ID_valid), 32'(m_valid));
      check("ifid_instr",  o_IF_ID_instruction, m_instr);
      check("ifid_pc4",    o_IF_ID_pc_plus4, m_pc4);
      check("stall_count", o_stall_count, m_stall);
      check("flush_count", o_flush_count, m_flush);
    end
    @(posedge clk);
    model_update();
  endtask

  task automatic idle_ctrl();
    s_reset = 1'b1; s_pk = 1'b0; s_ik = 1'b0; s_fl = 1'b0; s_bf = 1'b0; s_jump = JUMP_NONE;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; checking = 1'b0;
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_bufdata = '0; m_rdata = '0;
    m_stall = '0; m_flush = '0; m_valid = 1'b0; m_buf = 1'b0; m_out = 1'b0;
    m_stale = 1'b0; m_wait = 0; exp_req = 1'b0;
    s_bt = '0; s_jt = '0; s_jrt = '0;
    idle_ctrl();
    s_reset = 1'b0;
    step();
    checking = 1'b1;
    steps(2);

    // streaming after reset release: one word every second cycle
    idle_ctrl();
    steps(4);
    #2;
    check("stream_pc",    o_pc, 32'h0040_0008);
    check("stream_valid", 32'(o_IF_ID_valid), 32'd1);
    check("stream_pc4",   o_IF_ID_pc_plus4, 32'h0040_0008);

    // branch while waiting: stale word dropped, refetch from target
    dly_min = 1; dly_max = 1;
    step();
    s_bf = 1'b1; s_bt = 32'h0040_0100;
    step();
    s_bf = 1'b0;
    #2;
    check("br_pc",    o_pc, 32'h0040_0100);
    check("br_valid", 32'(o_IF_ID_valid), 32'd0);
    step();
    #2;
    check("br_addr",  o_imem_addr, 32'h0040_0100);
    dly_min = 0; dly_max = 0;
    step();

    // keep during response: buffered word appears on release
    s_pk = 1'b1; s_ik = 1'b1;
    steps(3);
    idle_ctrl();
    step();
    #2;
    check("hold_pc",    o_pc, 32'h0040_0104);
    check("hold_valid", 32'(o_IF_ID_valid), 32'd1);

    // jr stalled on a dependency: keep+flush holds, redirect after keep drops
    s_pk = 1'b1; s_ik = 1'b1; s_fl = 1'b1; s_jump = JUMP_JR; s_jrt = 32'h0040_0040;
    steps(2);
    #2;
    check("jr_keep_pc",    o_pc, 32'h0040_0104);
    check("jr_keep_valid", 32'(o_IF_ID_valid), 32'd1);
    s_pk = 1'b0; s_ik = 1'b0;
    step();
    #2;
    check("jr_addr",  o_imem_addr, 32'h0040_0040);
    check("jr_valid", 32'(o_IF_ID_valid), 32'd0);
    idle_ctrl();

    // reset while waiting: late response discarded, restart at RESET_PC
    dly_min = 2; dly_max = 2;
    step();
    s_reset = 1'b0;
    step();
    s_reset = 1'b1; dly_min = 0; dly_max = 0;
    step();
    check("rst_drop_req", 32'(o_imem_req), 32'd0);
    step();
    #2;
    check("rst_addr",  o_imem_addr, RST_PC);
    check("rst_valid", 32'(o_IF_ID_valid), 32'd0);

    // counters: 5 keep cycles, 2 flush cycles
    s_reset = 1'b0;
    step();
    idle_ctrl(); s_pk = 1'b1;
    steps(5);
    s_pk = 1'b0; s_fl = 1'b1;
    steps(2);
    s_fl = 1'b0;
    #2;
`ifdef FETCH_PERF_CNT_EN
    check("stall_5", o_stall_count, 32'd5);
    check("flush_2", o_flush_count, 32'd2);
`else
    check("stall_0", o_stall_count, 32'd0);
    check("flush_0", o_flush_count, 32'd0);
`endif

    // PC wrap at the top of the address space
    s_reset = 1'b0;
    step();
    idle_ctrl(); s_bf = 1'b1; s_bt = 32'hFFFF_FFFC;
    step();
    s_bf = 1'b0;
    steps(3);
    #2;
    check("wrap_pc",    o_pc, 32'h0000_0000);
    check("wrap_pc4",   o_IF_ID_pc_plus4, 32'h0000_0000);
    check("wrap_valid", 32'(o_IF_ID_valid), 32'd1);

    // random traffic
    gnt_always = 1'b0; dly_min = 0; dly_max = 3;
    for (int i = 0; i < 1500; i++) begin
      s_reset = ($urandom_range(0, 63) != 0);
      s_bf    = ($urandom_range(0, 15) == 0);
      s_pk    = ($urandom_range(0, 5) == 0);
      s_ik    = ($urandom_range(0, 5) == 0);
      s_fl    = ($urandom_range(0, 9) == 0);
      s_jump  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : JUMP_NONE;
      s_bt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      s_jt    = $urandom() & 32'hFFFF_FFFC;
      s_jrt   = $urandom() & 32'hFFFF_FFFC;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
